// File: rtl/ni_config_pkg.sv
// Shared NI config-space definitions: bank ids, IRQ bank register map and
// STATUS word layout used by the interrupt bank and its software model.
package ni_config_pkg;

    localparam logic [2:0]  IRQ_BANK   = 3'b100;
    localparam logic [31:0] EMPTY_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IRQ_POP_DATA   = 2'd0,
        IRQ_POP_REMOTE = 2'd1,
        IRQ_STATUS     = 2'd2,
        IRQ_RSVD       = 2'd3
    } irq_reg_e;

    localparam int STATUS_DATA_OVF   = 31;
    localparam int STATUS_REMOTE_OVF = 30;
    localparam int STATUS_REMOTE_CNT = 8;
    localparam int STATUS_DATA_CNT   = 0;

    function automatic logic [31:0] irq_status_word(input logic d_ovf, input logic r_ovf,
                                                    input logic [7:0] d_cnt, input logic [7:0] r_cnt);
        logic [31:0] w;
        w = '0;
        w[STATUS_DATA_OVF]            = d_ovf;
        w[STATUS_REMOTE_OVF]          = r_ovf;
        w[STATUS_REMOTE_CNT +: 8]     = r_cnt;
        w[STATUS_DATA_CNT +: 8]       = d_cnt;
        return w;
    endfunction

endpackage

// File: rtl/irq_unit_fifo_if.sv
// Config-bus slice seen by one NI config bank: request strobes in, registered
// read data and error back out.
interface irq_unit_fifo_if;
    logic [13:0] config_addr;
    logic        config_en;
    logic        config_wr;
    logic [31:0] config_wdata;
    logic        sel;
    logic [31:0] rdata;
    logic        error;

    modport master (output config_addr, config_en, config_wr, config_wdata, sel,
                    input  rdata, error);
    modport slave  (input  config_addr, config_en, config_wr, config_wdata, sel,
                    output rdata, error);
endinterface

// File: rtl/irq_queue.sv
// Circular interrupt-entry queue. A pop on a full queue frees the slot that a
// same-cycle push refills, so full+push+pop never overflows.
module irq_queue #(
    parameter  int DEPTH       = 16,
    parameter  int ENTRY_WIDTH = 16,
    localparam int PTR_W       = $clog2(DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [ENTRY_WIDTH-1:0] din_i,
    output logic [ENTRY_WIDTH-1:0] dout_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop)  head_d = head_q + PTR_W'(1);
        if (do_push) tail_d = tail_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is left unreset; pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[tail_q] <= din_i;
    end

    assign dout_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/irq_unit_fifo.sv
// NI config bank 3'b100: DATA and REMOTE interrupt queues drained by
// processor reads, with sticky overflow flags and one level irq per queue.
module irq_unit_fifo
    import ni_config_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ENTRY_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    irq_unit_fifo_if.slave         bus,
    input  logic                   push_data,
    input  logic                   push_remote,
    input  logic [ENTRY_WIDTH-1:0] irq_entry,
    output logic                   data_irq,
    output logic                   remote_irq
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   acc, rd_acc, status_rd, pop_data, pop_remote;
    irq_reg_e               reg_sel;
    logic [ENTRY_WIDTH-1:0] d_head, r_head;
    logic [CNT_W-1:0]       d_count, r_count;
    logic                   d_full, r_full, d_empty, r_empty;
    logic [31:0]            rdata_q, rdata_d;
    logic                   error_q, error_d;
    logic                   d_ovf_q, d_ovf_d, r_ovf_q, r_ovf_d;
    logic                   unused_bits;

    assign acc        = bus.config_en & bus.sel;
    assign rd_acc     = acc & ~bus.config_wr;
    assign reg_sel    = irq_reg_e'(bus.config_addr[1:0]);
    assign pop_data   = rd_acc & (reg_sel == IRQ_POP_DATA);
    assign pop_remote = rd_acc & (reg_sel == IRQ_POP_REMOTE);
    assign status_rd  = rd_acc & (reg_sel == IRQ_STATUS);
    assign unused_bits = ^{bus.config_wdata, bus.config_addr[13:2]};

    irq_queue #(.DEPTH(DEPTH), .ENTRY_WIDTH(ENTRY_WIDTH)) u_data_q (
        .clk(clk), .reset(reset), .push_i(push_data), .pop_i(pop_data), .din_i(irq_entry),
        .dout_o(d_head), .count_o(d_count), .full_o(d_full), .empty_o(d_empty)
    );

    irq_queue #(.DEPTH(DEPTH), .ENTRY_WIDTH(ENTRY_WIDTH)) u_remote_q (
        .clk(clk), .reset(reset), .push_i(push_remote), .pop_i(pop_remote), .din_i(irq_entry),
        .dout_o(r_head), .count_o(r_count), .full_o(r_full), .empty_o(r_empty)
    );

    always_comb begin
        rdata_d = '0;
        error_d = 1'b0;
        if (bus.config_wr) begin
            error_d = 1'b1;
        end else begin
            unique case (reg_sel)
                IRQ_POP_DATA:   rdata_d = d_empty ? EMPTY_WORD : 32'(d_head);
                IRQ_POP_REMOTE: rdata_d = r_empty ? EMPTY_WORD : 32'(r_head);
                IRQ_STATUS:     rdata_d = irq_status_word(d_ovf_q, r_ovf_q, 8'(d_count), 8'(r_count));
                default:        error_d = 1'b1;
            endcase
        end
    end

    // A drop in the same cycle as a STATUS read must survive the clear.
    assign d_ovf_d = (push_data   & d_full & ~pop_data)   | (d_ovf_q & ~status_rd);
    assign r_ovf_d = (push_remote & r_full & ~pop_remote) | (r_ovf_q & ~status_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            error_q <= 1'b0;
            d_ovf_q <= 1'b0;
            r_ovf_q <= 1'b0;
        end else begin
            if (acc) begin
                rdata_q <= rdata_d;
                error_q <= error_d;
            end
            d_ovf_q <= d_ovf_d;
            r_ovf_q <= r_ovf_d;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.error  = error_q;
    assign data_irq   = ~d_empty;
    assign remote_irq = ~r_empty;

endmodule

// File: tb/tb_irq_unit_fifo.sv
// Scoreboard bench for irq_unit_fifo: a queue-based reference model predicts
// every bus response and irq level cycle by cycle.
module tb_irq_unit_fifo;
    import ni_config_pkg::*;

    localparam int DEPTH = 16;
    localparam int EW    = 16;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } resp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push_data = 1'b0;
    logic          push_remote = 1'b0;
    logic [EW-1:0] irq_entry = '0;
    logic          data_irq, remote_irq;

    irq_unit_fifo_if bus();

    irq_unit_fifo #(.DEPTH(DEPTH), .ENTRY_WIDTH(EW)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .push_data(push_data), .push_remote(push_remote), .irq_entry(irq_entry),
        .data_irq(data_irq), .remote_irq(remote_irq)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] dq[$];
    logic [15:0] rq[$];
    bit          m_dovf = 0, m_rovf = 0;
    logic [31:0] last_rd = '0;
    logic        last_err = 1'b0;
    resp_t       exp_q[$];

    // One clock of stimulus; predicts the response, then compares it after the edge.
    task automatic step(input string tag, input bit pd, input bit pr, input logic [15:0] ent,
                        input bit en, input bit s, input bit wr, input logic [1:0] a);
        resp_t e, got;
        bit popd = 0, popr = 0, clr = 0;
        int dn = dq.size(), rn = rq.size();
        e.rd = last_rd; e.err = last_err;
        if (en && s) begin
            e.rd = '0; e.err = 1'b0;
            if (wr) e.err = 1'b1;
            else case (a)
                2'd0: if (dn != 0) begin e.rd = {16'h0, dq[0]}; popd = 1; end else e.rd = EMPTY_WORD;
                2'd1: if (rn != 0) begin e.rd = {16'h0, rq[0]}; popr = 1; end else e.rd = EMPTY_WORD;
                2'd2: begin e.rd = {m_dovf, m_rovf, 14'h0, 8'(rn), 8'(dn)}; clr = 1; end
                default: e.err = 1'b1;
            endcase
        end
        exp_q.push_back(e);
        push_data = pd; push_remote = pr; irq_entry = ent;
        bus.config_en = en; bus.sel = s; bus.config_wr = wr;
        bus.config_addr = {12'($urandom), a}; bus.config_wdata = $urandom;
        if (popd) void'(dq.pop_front());
        if (popr) void'(rq.pop_front());
        if (clr) begin m_dovf = 0; m_rovf = 0; end
        if (pd) begin if (dn < DEPTH || popd) dq.push_back(ent); else m_dovf = 1; end
        if (pr) begin if (rn < DEPTH || popr) rq.push_back(ent); else m_rovf = 1; end
        @(posedge clk); #1;
        push_data = 0; push_remote = 0; bus.config_en = 0; bus.sel = 0; bus.config_wr = 0;
        e = exp_q.pop_front();
        got.rd = bus.rdata; got.err = bus.error;
        last_rd = e.rd; last_err = e.err;
        checks++;
        if (got.rd !== e.rd || got.err !== e.err) begin
            errors++;
            $display("FAIL %s resp: got rdata=%h error=%b, want rdata=%h error=%b", tag, got.rd, got.err, e.rd, e.err);
        end
        checks++;
        if (data_irq !== (dq.size() != 0) || remote_irq !== (rq.size() != 0)) begin
            errors++;
            $display("FAIL %s irq: got data=%b remote=%b, want data=%b remote=%b", tag, data_irq, remote_irq,
                     dq.size() != 0, rq.size() != 0);
        end
    endtask

    task automatic expect_status(input string tag, input logic [31:0] want);
        step(tag, 0, 0, '0, 1, 1, 0, 2'd2);
        checks++;
        if (bus.rdata !== want) begin
            errors++;
            $display("FAIL %s status: got %h, want %h", tag, bus.rdata, want);
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1; push_data = 1; push_remote = 1; irq_entry = 16'hDEAD;
        bus.config_en = 1; bus.sel = 1; bus.config_wr = 0; bus.config_addr = '0;
        @(posedge clk); #1;
        reset = 0; push_data = 0; push_remote = 0; bus.config_en = 0; bus.sel = 0;
        dq.delete(); rq.delete(); m_dovf = 0; m_rovf = 0; last_rd = '0; last_err = 0;
        checks++;
        if (bus.rdata !== 32'h0 || bus.error !== 1'b0 || data_irq !== 1'b0 || remote_irq !== 1'b0) begin
            errors++;
            $display("FAIL %s: got rdata=%h error=%b data_irq=%b remote_irq=%b, want all zero",
                     tag, bus.rdata, bus.error, data_irq, remote_irq);
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
        step("empty_pop", 0, 0, '0, 1, 1, 0, 2'd0);
        checks++;
        if (bus.rdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL empty_pop_word: got %h, want ffffffff", bus.rdata);
        end
    endtask

    task automatic test_basic_data();
        step("push40", 1, 0, 16'h0040, 0, 0, 0, 2'd0);
        step("push80", 1, 0, 16'h0080, 0, 0, 0, 2'd0);
        expect_status("two_entries", 32'h0000_0002);
        step("pop40", 0, 0, '0, 1, 1, 0, 2'd0);
        step("pop80", 0, 0, '0, 1, 1, 0, 2'd0);
        checks++;
        if (bus.rdata !== 32'h0000_0080 || data_irq !== 1'b0) begin
            errors++;
            $display("FAIL drain_data: got rdata=%h data_irq=%b, want 00000080 0", bus.rdata, data_irq);
        end
    endtask

    task automatic test_remote_overflow();
        for (int i = 0; i < 17; i++) step("rpush", 0, 1, 16'h0100 + 16'(i), 0, 0, 0, 2'd0);
        expect_status("ovf_status", 32'h4000_1000);
        expect_status("ovf_cleared", 32'h0000_1000);
        for (int i = 0; i < 16; i++) step("rpop", 0, 0, '0, 1, 1, 0, 2'd1);
    endtask

    task automatic test_push_pop_same_cycle();
        for (int i = 0; i < 16; i++) step("rfill", 0, 1, 16'h0200 + 16'(i), 0, 0, 0, 2'd0);
        step("full_pushpop", 0, 1, 16'h0300, 1, 1, 0, 2'd1);
        expect_status("full_pushpop_status", 32'h0000_1000);
        for (int i = 0; i < 40; i++) step("wrap_pair", 0, 1, 16'h0400 + 16'(i), 1, 1, 0, 2'd1);
        for (int i = 0; i < 16; i++) step("rdrain", 0, 0, '0, 1, 1, 0, 2'd1);
        step("empty_pushpop", 1, 0, 16'h0077, 1, 1, 0, 2'd0);
        expect_status("empty_pushpop_status", 32'h0000_0001);
        step("pop77", 0, 0, '0, 1, 1, 0, 2'd0);
    endtask

    task automatic test_ovf_vs_status();
        for (int i = 0; i < 16; i++) step("dfill", 1, 0, 16'h0500 + 16'(i), 0, 0, 0, 2'd0);
        step("drop_and_status", 1, 0, 16'h0BAD, 1, 1, 0, 2'd2);
        expect_status("set_wins", 32'h8000_0010);
        for (int i = 0; i < 16; i++) step("ddrain", 0, 0, '0, 1, 1, 0, 2'd0);
        step("push_both", 1, 1, 16'hABCD, 0, 0, 0, 2'd0);
        expect_status("both_status", 32'h0000_0101);
        step("pop_both_d", 0, 0, '0, 1, 1, 0, 2'd0);
        step("pop_both_r", 0, 0, '0, 1, 1, 0, 2'd1);
    endtask

    task automatic test_errors();
        step("push55", 1, 0, 16'h0055, 0, 0, 0, 2'd0);
        step("write0", 0, 0, '0, 1, 1, 1, 2'd0);
        step("read3", 0, 0, '0, 1, 1, 0, 2'd3);
        checks++;
        if (bus.error !== 1'b1 || bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL read3_err: got error=%b rdata=%h, want 1 00000000", bus.error, bus.rdata);
        end
        step("nosel", 0, 0, '0, 1, 0, 0, 2'd0);
        expect_status("after_errors", 32'h0000_0001);
        step("pop55", 0, 0, '0, 1, 1, 0, 2'd0);
    endtask

    task automatic test_reset_traffic();
        for (int i = 0; i < 5; i++) step("pre_reset_push", 1, 0, 16'h0600 + 16'(i), 0, 0, 0, 2'd0);
        do_reset("reset_traffic");
        expect_status("post_reset_status", 32'h0000_0000);
        step("post_reset_pop", 0, 0, '0, 1, 1, 0, 2'd0);
    endtask

    initial begin
        bus.config_en = 0; bus.sel = 0; bus.config_wr = 0;
        bus.config_addr = '0; bus.config_wdata = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic_data();
        test_remote_overflow();
        test_push_pop_same_cycle();
        test_ovf_vs_status();
        test_errors();
        test_reset_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
